moore_seq_7seg: RTL and testbench

- Parametrised Moore sequencer with on-board rate divider and 7-segment decode.
- State advances one step per divided tick, by +1 or by +JUMP modulo MODULUS depending on `mode`.
- Supports hold, synchronous load, and mode-dependent display blanking.
- Sits between board buttons/switches and a single active-low 7-segment digit; the whole block runs on one clock and uses a tick enable, with no derived clock.

---
 rtl/moore_seq_7seg_if.sv | 31 +++
 rtl/moore_seq_7seg.sv | 110 +++++++++++
 tb/tb_moore_seq_7seg.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/moore_seq_7seg_if.sv
// Control inputs and sequencer/display outputs of moore_seq_7seg; master drives controls.
// `dir` exists only when SEQ_DOWN_EN is defined.
interface moore_seq_7seg_if #(parameter int STATE_W = 4);
   logic               mode;
   logic               hold;
   logic               load;
   logic [STATE_W-1:0] load_val;
   logic               tick;
   logic [STATE_W-1:0] state;
   logic               wrap;
   logic [6:0]         out;
`ifdef SEQ_DOWN_EN
   logic               dir;
`endif

   modport master (
`ifdef SEQ_DOWN_EN
      output dir,
`endif
      output mode, hold, load, load_val,
      input  tick, state, wrap, out
   );

   modport slave (
`ifdef SEQ_DOWN_EN
      input  dir,
`endif
      input  mode, hold, load, load_val,
      output tick, state, wrap, out
   );
endinterface

// File: rtl/moore_seq_7seg.sv
// Moore sequencer stepping +1/+JUMP mod MODULUS once per DIV_COUNT clk, driving one active-low 7-seg digit.
// Step every DIV_COUNT edges (load restarts count, hold freezes); SEQ_DOWN_EN adds a `dir` down-count input.
module moore_seq_7seg #(
   parameter int DIV_COUNT = 25000000,
   parameter int MODULUS   = 6,
   parameter int JUMP      = 2,
   parameter int STATE_W   = 4
) (
   input  logic               clk,
   input  logic               reset,
   moore_seq_7seg_if.slave    bus
);
   localparam int DIV_W = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
   localparam int SW1   = STATE_W + 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_COUNT - 1);
   localparam logic [SW1-1:0]   MOD_X    = SW1'(MODULUS);
   localparam logic [SW1-1:0]   JUMP_X   = SW1'(JUMP);
   localparam logic [SW1-1:0]   ONE_X    = SW1'(1);

   logic [DIV_W-1:0]   div_cnt;
   logic [STATE_W-1:0] state_q;
   logic               wrap_q;
   logic               tick_w;
   logic [SW1-1:0]     step;
   logic [SW1-1:0]     cur;
   logic [SW1-1:0]     sum;
   logic [SW1-1:0]     nxt;
   logic               nxt_wrap;
   logic [3:0]         nib;
   logic [6:0]         seg;

   assign tick_w = (div_cnt == DIV_LAST) & ~bus.hold & ~bus.load;

   always_comb begin
      step     = bus.mode ? JUMP_X : ONE_X;
      cur      = {1'b0, state_q};
      sum      = cur + step;
      nxt      = sum;
      nxt_wrap = 1'b0;
      if (sum >= MOD_X) begin
         nxt      = sum - MOD_X;
         nxt_wrap = 1'b1;
      end
`ifdef SEQ_DOWN_EN
      if (bus.dir) begin
         if (cur < step) begin
            nxt      = cur + MOD_X - step;
            nxt_wrap = 1'b1;
         end else begin
            nxt      = cur - step;
            nxt_wrap = 1'b0;
         end
      end
`endif
      // an out-of-range state that is still out of range after one correction lands on 0
      if (nxt >= MOD_X)
         nxt = '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
         state_q <= '0;
         wrap_q  <= 1'b0;
      end else if (bus.load) begin
         if ({1'b0, bus.load_val} < MOD_X)
            state_q <= bus.load_val;
         div_cnt <= '0;
         wrap_q  <= 1'b0;
      end else if (bus.hold) begin
         wrap_q <= 1'b0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt <= '0;
         state_q <= nxt[STATE_W-1:0];
         wrap_q  <= nxt_wrap;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
         wrap_q  <= 1'b0;
      end
   end

   assign nib = 4'(state_q);

   always_comb begin
      seg = 7'b1111111;
      case (nib)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0010000;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b1000110;
         4'hD: seg = 7'b0100001;
         4'hE: seg = 7'b0000110;
         4'hF: seg = 7'b0001110;
      endcase
   end

   assign bus.tick  = tick_w;
   assign bus.state = state_q;
   assign bus.wrap  = wrap_q;
   assign bus.out   = bus.mode ? 7'b1111111 : seg;
endmodule

// File: tb/tb_moore_seq_7seg.sv
// Randomized self-checking bench for moore_seq_7seg (JUMP=2 and JUMP=5 instances share stimulus).
module tb_moore_seq_7seg;
   localparam int DIV_COUNT = 4;
   localparam int MODULUS   = 6;
   localparam int JUMP      = 2;
   localparam int STATE_W   = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic mode = 1'b0;
   logic hold = 1'b0;
   logic load = 1'b0;
   logic [STATE_W-1:0] load_val = '0;
`ifdef SEQ_DOWN_EN
   logic dir = 1'b0;
`endif

   int checks = 0;
   int errors = 0;
   int m_cnt, m_state, m_wrap, m5_state, m5_wrap;

   logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   moore_seq_7seg_if #(.STATE_W(STATE_W)) bus ();
   moore_seq_7seg_if #(.STATE_W(STATE_W)) bus5 ();

   assign bus.mode      = mode;
   assign bus.hold      = hold;
   assign bus.load      = load;
   assign bus.load_val  = load_val;
   assign bus5.mode     = mode;
   assign bus5.hold     = hold;
   assign bus5.load     = load;
   assign bus5.load_val = load_val;
`ifdef SEQ_DOWN_EN
   assign bus.dir  = dir;
   assign bus5.dir = dir;
`endif

   moore_seq_7seg #(.DIV_COUNT(DIV_COUNT), .MODULUS(MODULUS), .JUMP(JUMP), .STATE_W(STATE_W))
      dut (.clk(clk), .reset(reset), .bus(bus));
   moore_seq_7seg #(.DIV_COUNT(DIV_COUNT), .MODULUS(MODULUS), .JUMP(5), .STATE_W(STATE_W))
      dut5 (.clk(clk), .reset(reset), .bus(bus5));

   always #5 clk = ~clk;

   function automatic logic [6:0] exp_out(int st, logic md);
      return md ? 7'b1111111 : seg_tab[st];
   endfunction

   function automatic logic exp_tick();
      return (m_cnt == DIV_COUNT - 1) && !hold && !load;
   endfunction

   task automatic model_reset();
      m_cnt = 0; m_state = 0; m_wrap = 0; m5_state = 0; m5_wrap = 0;
   endtask

   task automatic model_next(input int jump, inout int st, output int wr);
      int s;
      s = mode ? jump : 1;
`ifdef SEQ_DOWN_EN
      if (dir) begin
         wr = (st - s < 0) ? 1 : 0;
         st = (st - s + MODULUS) % MODULUS;
         return;
      end
`endif
      wr = (st + s >= MODULUS) ? 1 : 0;
      st = (st + s) % MODULUS;
   endtask

   // one clock edge, model advanced from the same inputs the DUT sampled; returns at the falling edge
   task automatic cycle();
      @(posedge clk);
      if (load) begin
         if (int'(load_val) < MODULUS) begin
            m_state = int'(load_val);
            m5_state = int'(load_val);
         end
         m_cnt = 0; m_wrap = 0; m5_wrap = 0;
      end else if (hold) begin
         m_wrap = 0; m5_wrap = 0;
      end else if (m_cnt == DIV_COUNT - 1) begin
         m_cnt = 0;
         model_next(JUMP, m_state, m_wrap);
         model_next(5, m5_state, m5_wrap);
      end else begin
         m_cnt++; m_wrap = 0; m5_wrap = 0;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      model_reset();
      repeat (2) @(negedge clk);
      checks++; if (bus.state !== 4'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", bus.state); end
      checks++; if (bus.wrap !== 1'b0) begin errors++; $display("FAIL rst_wrap got %b exp 0", bus.wrap); end
      checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL rst_tick got %b exp 0", bus.tick); end
      checks++; if (bus.out !== 7'b1000000) begin errors++; $display("FAIL rst_out got %b exp 1000000", bus.out); end
      mode = 1'b1; #1;
      checks++; if (bus.out !== 7'b1111111) begin errors++; $display("FAIL rst_out_blank got %b exp 1111111", bus.out); end
      mode = 1'b0;
      reset = 1'b0;
   endtask

   task automatic test_up_count();
      mode = 1'b0;
      for (int i = 0; i < 6 * DIV_COUNT; i++) begin
         cycle();
         checks++; if (bus.state !== STATE_W'(m_state)) begin errors++; $display("FAIL up_state cyc %0d got %0d exp %0d", i, bus.state, m_state); end
         checks++; if (bus.wrap !== 1'(m_wrap)) begin errors++; $display("FAIL up_wrap cyc %0d got %b exp %0d", i, bus.wrap, m_wrap); end
         checks++; if (bus.tick !== exp_tick()) begin errors++; $display("FAIL up_tick cyc %0d got %b exp %b", i, bus.tick, exp_tick()); end
         checks++; if (bus.out !== exp_out(m_state, mode)) begin errors++; $display("FAIL up_out cyc %0d got %b exp %b", i, bus.out, exp_out(m_state, mode)); end
      end
      checks++; if (bus.state !== 4'd0 || bus.wrap !== 1'b1) begin errors++; $display("FAIL up_wrap_5to0 got state %0d wrap %b exp 0/1", bus.state, bus.wrap); end
   endtask

   task automatic test_jump();
      load = 1'b1; load_val = 4'd0;
      cycle();
      load = 1'b0; mode = 1'b1;
      for (int i = 0; i < 6 * DIV_COUNT; i++) begin
         cycle();
         checks++; if (bus.state !== STATE_W'(m_state) || bus.wrap !== 1'(m_wrap)) begin errors++; $display("FAIL j2_state_wrap cyc %0d got %0d/%b exp %0d/%0d", i, bus.state, bus.wrap, m_state, m_wrap); end
         checks++; if (bus5.state !== STATE_W'(m5_state) || bus5.wrap !== 1'(m5_wrap)) begin errors++; $display("FAIL j5_state_wrap cyc %0d got %0d/%b exp %0d/%0d", i, bus5.state, bus5.wrap, m5_state, m5_wrap); end
         checks++; if (bus.out !== 7'b1111111) begin errors++; $display("FAIL jump_blank cyc %0d got %b exp 1111111", i, bus.out); end
      end
      mode = 1'b0;
   endtask

   task automatic test_hold();
      int saved;
      int seen;
      for (int k = 0; k < DIV_COUNT && m_cnt != 2; k++) cycle();
      hold = 1'b1; saved = m_state;
      for (int i = 0; i < 10; i++) begin
         cycle();
         checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL hold_tick cyc %0d got %b exp 0", i, bus.tick); end
         checks++; if (bus.state !== STATE_W'(saved)) begin errors++; $display("FAIL hold_state cyc %0d got %0d exp %0d", i, bus.state, saved); end
      end
      hold = 1'b0;
      seen = -1;
      for (int k = 1; k <= 2 * DIV_COUNT; k++) begin
         cycle();
         if (bus.state !== STATE_W'(saved)) begin seen = k; break; end
      end
      checks++; if (seen != 2) begin errors++; $display("FAIL hold_release_edges got %0d exp 2", seen); end
      checks++; if (bus.state !== STATE_W'(m_state)) begin errors++; $display("FAIL hold_after got %0d exp %0d", bus.state, m_state); end
   endtask

   task automatic test_load();
      int saved;
      int seen;
      for (int k = 0; k < DIV_COUNT && m_cnt != DIV_COUNT - 1; k++) cycle();
      checks++; if (bus.tick !== 1'b1) begin errors++; $display("FAIL load_pre_tick got %b exp 1", bus.tick); end
      load = 1'b1; load_val = 4'd3; #1;
      checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL load_tick_masked got %b exp 0", bus.tick); end
      cycle();
      load = 1'b0;
      checks++; if (bus.state !== 4'd3 || bus.wrap !== 1'b0) begin errors++; $display("FAIL load3 got %0d/%b exp 3/0", bus.state, bus.wrap); end
      seen = -1;
      for (int k = 1; k <= 2 * DIV_COUNT; k++) begin
         cycle();
         if (bus.state !== 4'd3) begin seen = k; break; end
      end
      checks++; if (seen != DIV_COUNT) begin errors++; $display("FAIL load3_next_step got %0d exp %0d", seen, DIV_COUNT); end
      cycle();
      saved = m_state;
      load = 1'b1; load_val = 4'd7;
      cycle();
      load = 1'b0;
      checks++; if (bus.state !== STATE_W'(saved)) begin errors++; $display("FAIL load7_state got %0d exp %0d", bus.state, saved); end
      seen = -1;
      for (int k = 1; k <= 2 * DIV_COUNT; k++) begin
         cycle();
         if (bus.state !== STATE_W'(saved)) begin seen = k; break; end
      end
      checks++; if (seen != DIV_COUNT) begin errors++; $display("FAIL load7_prescaler got %0d exp %0d", seen, DIV_COUNT); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         mode     = 1'($urandom_range(0, 1));
         hold     = ($urandom_range(0, 7) == 0);
         load     = ($urandom_range(0, 9) == 0);
         load_val = 4'($urandom_range(0, 15));
`ifdef SEQ_DOWN_EN
         dir      = 1'($urandom_range(0, 1));
`endif
         #1;
         checks++; if (bus.tick !== exp_tick()) begin errors++; $display("FAIL rnd_tick cyc %0d got %b exp %b", i, bus.tick, exp_tick()); end
         checks++; if (bus.out !== exp_out(m_state, mode)) begin errors++; $display("FAIL rnd_out cyc %0d got %b exp %b", i, bus.out, exp_out(m_state, mode)); end
         cycle();
         checks++; if (bus.state !== STATE_W'(m_state) || bus.wrap !== 1'(m_wrap)) begin errors++; $display("FAIL rnd_j2 cyc %0d got %0d/%b exp %0d/%0d", i, bus.state, bus.wrap, m_state, m_wrap); end
         checks++; if (bus5.state !== STATE_W'(m5_state) || bus5.wrap !== 1'(m5_wrap)) begin errors++; $display("FAIL rnd_j5 cyc %0d got %0d/%b exp %0d/%0d", i, bus5.state, bus5.wrap, m5_state, m5_wrap); end
      end
      hold = 1'b0; load = 1'b0; mode = 1'b0;
`ifdef SEQ_DOWN_EN
      dir = 1'b0;
`endif
   endtask

   task automatic test_async_reset();
      load = 1'b1; load_val = 4'd4; mode = 1'b0;
      cycle();
      load = 1'b0;
      cycle();
      checks++; if (bus.state !== 4'd4) begin errors++; $display("FAIL areset_pre got %0d exp 4", bus.state); end
      #2 reset = 1'b1;
      #1;
      checks++; if (bus.state !== 4'd0 || bus.out !== 7'b1000000) begin errors++; $display("FAIL areset_now got %0d/%b exp 0/1000000", bus.state, bus.out); end
      checks++; if (bus.tick !== 1'b0 || bus.wrap !== 1'b0) begin errors++; $display("FAIL areset_tick_wrap got %b/%b exp 0/0", bus.tick, bus.wrap); end
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      for (int i = 0; i < DIV_COUNT; i++) begin
         cycle();
         checks++; if (bus.state !== STATE_W'(m_state)) begin errors++; $display("FAIL areset_after cyc %0d got %0d exp %0d", i, bus.state, m_state); end
      end
   endtask

`ifdef SEQ_DOWN_EN
   task automatic test_down();
      load = 1'b1; load_val = 4'd0;
      cycle();
      load = 1'b0; dir = 1'b1; mode = 1'b0;
      for (int i = 0; i < DIV_COUNT; i++) cycle();
      checks++; if (bus.state !== 4'd5 || bus.wrap !== 1'b1) begin errors++; $display("FAIL down_0to5 got %0d/%b exp 5/1", bus.state, bus.wrap); end
      for (int i = 0; i < 2 * DIV_COUNT; i++) begin
         cycle();
         checks++; if (bus.state !== STATE_W'(m_state) || bus.wrap !== 1'(m_wrap)) begin errors++; $display("FAIL down_seq cyc %0d got %0d/%b exp %0d/%0d", i, bus.state, bus.wrap, m_state, m_wrap); end
      end
      checks++; if (bus.state !== 4'd3) begin errors++; $display("FAIL down_end got %0d exp 3", bus.state); end
      dir = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_up_count();
      test_jump();
      test_hold();
      test_load();
      test_random();
      test_async_reset();
`ifdef SEQ_DOWN_EN
      test_down();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
